// File: rtl/sha256_padder_pkg.sv
// Shared types and constants for the SHA-256 message padder.
package sha256_padder_pkg;

  localparam int         BLOCK_W     = 512;
  localparam int         WORD_W      = 32;
  localparam int         BLOCK_WORDS = BLOCK_W / WORD_W;
  localparam logic [7:0] PAD_BYTE    = 8'h80;

  typedef enum logic [1:0] {
    FILL,
    PAD,
    ISSUE,
    BUSY
  } state_t;

endpackage

// File: rtl/sha256_padder_if.sv
// Word-stream and core-side signals of the SHA-256 padder.
// Optional: SHA256_PADDER_ERR_EN adds the sticky err flag.
interface sha256_padder_if;
  import sha256_padder_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [WORD_W-1:0]  in_data;
  logic               in_last;
  logic [2:0]         in_nbytes;
  logic               core_init;
  logic               core_next;
  logic [BLOCK_W-1:0] core_block;
  logic               core_ready;
  logic               core_final;
  logic               msg_done;
`ifdef SHA256_PADDER_ERR_EN
  logic               err;
`endif

  // Environment side: produces the message stream and models the core.
  modport master (
    output in_valid, in_data, in_last, in_nbytes, core_ready,
`ifdef SHA256_PADDER_ERR_EN
    input  err,
`endif
    input  in_ready, core_init, core_next, core_block, core_final, msg_done
  );

  // Padder side.
  modport slave (
    input  in_valid, in_data, in_last, in_nbytes, core_ready,
`ifdef SHA256_PADDER_ERR_EN
    output err,
`endif
    output in_ready, core_init, core_next, core_block, core_final, msg_done
  );

endinterface

// File: rtl/sha256_padder_pad_word.sv
// Masks the unused tail bytes of an incoming word and inserts the 0x80
// terminator right after the last message byte. A full last word cannot hold
// the terminator, so pad_pending tells the caller to emit it in the next slot.
module sha256_padder_pad_word
  import sha256_padder_pkg::*;
(
  input  logic [WORD_W-1:0] data,
  input  logic [2:0]        nbytes,
  input  logic              last,
  output logic [WORD_W-1:0] word,
  output logic [2:0]        eff_nbytes,
  output logic              pad_pending
);

  // Clamp byte count, zero bytes past the message, drop in the terminator.
  always_comb begin
    eff_nbytes  = (!last || nbytes > 3'd4) ? 3'd4 : nbytes;
    word        = data;
    for (int b = 0; b < 4; b++) begin
      if (3'(b) == eff_nbytes)     word[WORD_W-1-8*b -: 8] = PAD_BYTE;
      else if (3'(b) > eff_nbytes) word[WORD_W-1-8*b -: 8] = 8'h00;
    end
    pad_pending = last && (eff_nbytes == 3'd4);
  end

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 message front end: collects big-endian words, applies the 0x80 /
// zero-fill / 64-bit length padding, and hands 512-bit blocks to the core with
// init/next pulses paced by core_ready.
// Optional: SHA256_PADDER_ERR_EN drops malformed words and flags them on err.
module sha256_padder
  import sha256_padder_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input logic            clk,
  input logic            reset,
  sha256_padder_if.slave bus
);

  state_t state_q, state_n;
  // Word 0 lives in the top slot so the packed array maps straight onto core_block.
  logic [BLOCK_WORDS-1:0][WORD_W-1:0] words_q, words_n;
  logic [4:0]       idx_q, idx_n;
  logic [LEN_W-1:0] len_q, len_n;
  logic             first_q, first_n;
  logic             pend_q, pend_n;
  logic             final_q, final_n;
  logic             tail_q, tail_n;   // message ended, padding still in progress
  logic             low_q, low_n;     // core_ready seen low since the pulse
  logic [WORD_W-1:0] pw_word;
  logic [2:0]        pw_nbytes;
  logic              pw_pend;
  logic [63:0]       len64;
  logic [3:0]        slot;
  logic              drop;
`ifdef SHA256_PADDER_ERR_EN
  logic              err_q, err_n;
`endif

  sha256_padder_pad_word u_pad_word (
    .data        (bus.in_data),
    .nbytes      (bus.in_nbytes),
    .last        (bus.in_last),
    .word        (pw_word),
    .eff_nbytes  (pw_nbytes),
    .pad_pending (pw_pend)
  );

  assign len64          = 64'(len_q);
  assign slot           = 4'd15 - idx_q[3:0];
  assign bus.core_block = words_q;
`ifdef SHA256_PADDER_ERR_EN
  assign drop    = (bus.in_nbytes > 3'd4) || (bus.in_nbytes != 3'd4 && !bus.in_last);
  assign bus.err = err_q;
`else
  assign drop    = 1'b0;
`endif

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_n        = state_q;
    words_n        = words_q;
    idx_n          = idx_q;
    len_n          = len_q;
    first_n        = first_q;
    pend_n         = pend_q;
    final_n        = final_q;
    tail_n         = tail_q;
    low_n          = low_q;
`ifdef SHA256_PADDER_ERR_EN
    err_n          = err_q;
`endif
    bus.in_ready   = 1'b0;
    bus.core_init  = 1'b0;
    bus.core_next  = 1'b0;
    bus.core_final = 1'b0;
    bus.msg_done   = 1'b0;
    case (state_q)
      FILL: begin
        bus.in_ready = 1'b1;
`ifdef SHA256_PADDER_ERR_EN
        if (bus.in_valid && drop) err_n = 1'b1;
`endif
        if (bus.in_valid && !drop) begin
          words_n[slot] = pw_word;
          idx_n         = idx_q + 5'd1;
          len_n         = len_q + LEN_W'({pw_nbytes, 3'b000});
          final_n       = 1'b0;
          if (bus.in_last) begin
            tail_n  = 1'b1;
            pend_n  = pw_pend;
            // A last word filling slot 15 ships the block; padding resumes in the next one.
            state_n = (idx_q == 5'd15) ? ISSUE : PAD;
          end else if (idx_q == 5'd15) begin
            state_n = ISSUE;
          end
        end
      end
      PAD: begin
        if (idx_q == 5'd14 && !pend_q) begin
          words_n[1] = len64[63:32];
          words_n[0] = len64[31:0];
          final_n    = 1'b1;
          state_n    = ISSUE;
        end else begin
          words_n[slot] = pend_q ? {PAD_BYTE, 24'h0} : '0;
          pend_n        = 1'b0;
          idx_n         = idx_q + 5'd1;
          if (idx_q == 5'd15) begin
            final_n = 1'b0;
            state_n = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (bus.core_ready) begin
          bus.core_init  = first_q;
          bus.core_next  = !first_q;
          bus.core_final = final_q;
          first_n        = 1'b0;
          low_n          = 1'b0;
          state_n        = BUSY;
        end
      end
      BUSY: begin
        if (!bus.core_ready) begin
          low_n = 1'b1;
        end else if (low_q) begin
          words_n = '0;
          idx_n   = '0;
          low_n   = 1'b0;
          if (final_q) begin
            bus.msg_done = 1'b1;
            len_n        = '0;
            first_n      = 1'b1;
            tail_n       = 1'b0;
            state_n      = FILL;
          end else begin
            state_n = tail_q ? PAD : FILL;
          end
        end
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= FILL;
    else       state_q <= state_n;
  end

  // Block buffer, index, length and sequencing flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      words_q <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      first_q <= 1'b1;
      pend_q  <= 1'b0;
      final_q <= 1'b0;
      tail_q  <= 1'b0;
      low_q   <= 1'b0;
    end else begin
      words_q <= words_n;
      idx_q   <= idx_n;
      len_q   <= len_n;
      first_q <= first_n;
      pend_q  <= pend_n;
      final_q <= final_n;
      tail_q  <= tail_n;
      low_q   <= low_n;
    end
  end

`ifdef SHA256_PADDER_ERR_EN
  // Sticky malformed-word flag.
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_n;
  end
`endif

endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench for sha256_padder: messages are padded by a byte-level
// reference model and every issued block, pulse and flag is compared to it.
module tb_sha256_padder;
  import sha256_padder_pkg::*;

  localparam int TMO = 1000;
  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [511:0] LEN448    = {480'h0, 32'h000001C0};
  localparam logic [511:0] PAD512    = {32'h80000000, 448'h0, 32'h00000200};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sha256_padder_if bus();

  sha256_padder #(.LEN_W(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int           n_checks = 0;
  int           n_fail   = 0;
  bit           hung     = 1'b0;
  byte unsigned msg_q[$];
  logic [511:0] exp_blk[$];
  logic [511:0] cap_blk[$];

  function automatic void set_msg(input string s);
    msg_q.delete();
    for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
  endfunction

  function automatic void rand_msg(input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
  endfunction

  // Byte-level padding: message, 0x80, zeros to 56 mod 64, 64-bit bit length.
  function automatic void build_expected();
    byte unsigned    p[$];
    longint unsigned bits;
    logic [511:0]    v;
    p    = msg_q;
    bits = 64'(msg_q.size()) * 8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(8'(bits >> (8 * i)));
    exp_blk.delete();
    for (int b = 0; b < p.size() / 64; b++) begin
      v = '0;
      for (int k = 0; k < 64; k++) v = {v[503:0], p[b * 64 + k]};
      exp_blk.push_back(v);
    end
  endfunction

  task automatic drive_words(input bit gaps, input bit tail_empty);
    logic [31:0] wd[$];
    bit          wl[$];
    logic [2:0]  wn[$];
    int          n;
    int          i;
    n = msg_q.size();
    i = 0;
    while (i < n) begin
      logic [31:0] d;
      int          k;
      d = $urandom;
      k = (n - i >= 4) ? 4 : n - i;
      for (int j = 0; j < k; j++) d[31 - 8 * j -: 8] = msg_q[i + j];
      i += k;
      wd.push_back(d);
      wl.push_back((i == n) && !tail_empty);
      wn.push_back(3'(k));
    end
    if (n == 0 || tail_empty) begin
      wd.push_back($urandom);
      wl.push_back(1'b1);
      wn.push_back(3'd0);
    end
    for (int w = 0; w < wd.size(); w++) begin
      int cnt = 0;
      if (hung) break;
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      bus.in_valid  = 1'b1;
      bus.in_data   = wd[w];
      bus.in_last   = wl[w];
      bus.in_nbytes = wn[w];
      while (bus.in_ready !== 1'b1 && cnt < TMO && !hung) begin
        @(negedge clk);
        cnt++;
      end
      if (cnt >= TMO) begin
        n_checks++;
        n_fail++;
        hung = 1'b1;
        $display("FAIL in_ready_timeout: word %0d not accepted within %0d cycles", w, TMO);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic core_side(input int busy);
    int nb;
    nb = exp_blk.size();
    cap_blk.delete();
    #1;
    for (int b = 0; b < nb; b++) begin
      int cnt = 0;
      if (hung) return;
      while (!(bus.core_init || bus.core_next) && cnt < TMO) begin
        @(negedge clk);
        #1;
        cnt++;
      end
      if (cnt >= TMO) begin
        n_checks++;
        n_fail++;
        hung = 1'b1;
        $display("FAIL pulse_timeout: block %0d got no pulse, expected %0d blocks", b, nb);
        return;
      end
      cap_blk.push_back(bus.core_block);
      n_checks++;
      if (bus.core_init !== 1'(b == 0)) begin
        n_fail++;
        $display("FAIL core_init blk %0d: got %b expected %b", b, bus.core_init, (b == 0));
      end
      n_checks++;
      if (bus.core_next !== 1'(b != 0)) begin
        n_fail++;
        $display("FAIL core_next blk %0d: got %b expected %b", b, bus.core_next, (b != 0));
      end
      n_checks++;
      if (bus.core_final !== 1'(b == nb - 1)) begin
        n_fail++;
        $display("FAIL core_final blk %0d: got %b expected %b", b, bus.core_final, (b == nb - 1));
      end
      n_checks++;
      if (bus.core_block !== exp_blk[b]) begin
        n_fail++;
        $display("FAIL core_block blk %0d: got %h expected %h", b, bus.core_block, exp_blk[b]);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if ((bus.core_init | bus.core_next) !== 1'b0) begin
        n_fail++;
        $display("FAIL pulse_width blk %0d: got init=%b next=%b expected 0", b, bus.core_init, bus.core_next);
      end
      bus.core_ready = 1'b0;
      repeat (busy) begin
        @(negedge clk);
        #1;
        n_checks++;
        if ({bus.in_ready, bus.core_init, bus.core_next, bus.msg_done} !== 4'b0000) begin
          n_fail++;
          $display("FAIL busy_quiet blk %0d: got rdy/init/next/done=%b expected 0000", b,
                   {bus.in_ready, bus.core_init, bus.core_next, bus.msg_done});
        end
        n_checks++;
        if (bus.core_block !== exp_blk[b]) begin
          n_fail++;
          $display("FAIL busy_block blk %0d: got %h expected %h", b, bus.core_block, exp_blk[b]);
        end
      end
      bus.core_ready = 1'b1;
      #1;
      n_checks++;
      if (bus.msg_done !== 1'(b == nb - 1)) begin
        n_fail++;
        $display("FAIL msg_done blk %0d: got %b expected %b", b, bus.msg_done, (b == nb - 1));
      end
    end
  endtask

  task automatic run_msg(input int busy, input bit gaps, input bit tail);
    bit te;
    if (hung) return;
    te = tail && msg_q.size() > 0 && msg_q.size() % 4 == 0;
    build_expected();
    @(negedge clk);
    fork
      drive_words(gaps, te);
      core_side(busy);
    join
    if (hung) return;
    @(negedge clk);
    #1;
    n_checks++;
    if ({bus.in_ready, bus.core_init, bus.core_next} !== 3'b100) begin
      n_fail++;
      $display("FAIL idle_after_msg: got rdy/init/next=%b expected 100",
               {bus.in_ready, bus.core_init, bus.core_next});
    end
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.in_nbytes = '0;
    bus.core_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    n_checks++;
    if ({bus.core_init, bus.core_next, bus.core_final, bus.msg_done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_pulses: got %b expected 0000",
               {bus.core_init, bus.core_next, bus.core_final, bus.msg_done});
    end
    n_checks++;
    if (bus.core_block !== '0) begin
      n_fail++;
      $display("FAIL reset_block: got %h expected 0", bus.core_block);
    end
  endtask

  task automatic test_abc();
    set_msg("abc");
    run_msg(3, 1'b0, 1'b0);
    n_checks++;
    if (cap_blk.size() != 1 || cap_blk[0] !== ABC_BLK) begin
      n_fail++;
      $display("FAIL abc_block: got %0d blocks, first %h expected %h", cap_blk.size(),
               (cap_blk.size() > 0) ? cap_blk[0] : 512'h0, ABC_BLK);
    end
  endtask

  task automatic test_two_block();
    set_msg("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
    run_msg(2, 1'b0, 1'b0);
    n_checks++;
    if (cap_blk.size() != 2 || cap_blk[0][63:0] !== 64'h80000000_00000000 || cap_blk[1] !== LEN448) begin
      n_fail++;
      $display("FAIL two_block: got %0d blocks, last %h expected 2 blocks ending %h", cap_blk.size(),
               (cap_blk.size() > 0) ? cap_blk[cap_blk.size() - 1] : 512'h0, LEN448);
    end
  endtask

  task automatic test_empty();
    set_msg("");
    run_msg(2, 1'b0, 1'b0);
    n_checks++;
    if (cap_blk.size() != 1 || cap_blk[0] !== EMPTY_BLK) begin
      n_fail++;
      $display("FAIL empty_block: got %0d blocks, first %h expected %h", cap_blk.size(),
               (cap_blk.size() > 0) ? cap_blk[0] : 512'h0, EMPTY_BLK);
    end
  endtask

  task automatic test_full_block();
    rand_msg(64);
    run_msg(2, 1'b0, 1'b0);
    n_checks++;
    if (cap_blk.size() != 2 || cap_blk[1] !== PAD512) begin
      n_fail++;
      $display("FAIL full_block: got %0d blocks, last %h expected %h", cap_blk.size(),
               (cap_blk.size() > 0) ? cap_blk[cap_blk.size() - 1] : 512'h0, PAD512);
    end
  endtask

  task automatic test_backpressure();
    set_msg("abc");
    run_msg(50, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_data   = $urandom;
      bus.in_last   = 1'b0;
      bus.in_nbytes = 3'd4;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.core_block !== '0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_clear: got rdy=%b block %h expected rdy=1 block 0", bus.in_ready, bus.core_block);
    end
    set_msg("abc");
    run_msg(2, 1'b0, 1'b0);
    n_checks++;
    if (cap_blk.size() != 1 || cap_blk[0] !== ABC_BLK) begin
      n_fail++;
      $display("FAIL mid_reset_abc: got %0d blocks, first %h expected %h", cap_blk.size(),
               (cap_blk.size() > 0) ? cap_blk[0] : 512'h0, ABC_BLK);
    end
  endtask

  task automatic test_boundaries();
    int lens[8] = '{55, 56, 57, 60, 63, 64, 119, 120};
    for (int i = 0; i < 8; i++) begin
      rand_msg(lens[i]);
      run_msg($urandom_range(1, 3), 1'b1, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      rand_msg($urandom_range(0, 150));
      run_msg($urandom_range(1, 4), 1'b1, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_two_block();
    test_empty();
    test_full_block();
    test_backpressure();
    test_reset_mid();
    test_boundaries();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
